// File: rtl/rob_retire.sv
// In-order retirement stage of a reorder buffer: allocates tags at dispatch,
// captures writeback results by tag, and retires head entries in program order.
module rob_retire #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8,
    parameter int OPC_W  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alloc_valid,
    output logic                     alloc_ready,
    input  logic [OPC_W-1:0]         alloc_opcode,
    input  logic [3:0]               alloc_dest,
    output logic [$clog2(DEPTH)-1:0] alloc_tag,
    input  logic                     wb_valid,
    input  logic [$clog2(DEPTH)-1:0] wb_tag,
    input  logic [DATA_W-1:0]        wb_value,
    output logic                     commit_valid,
    input  logic                     commit_ready,
    output logic [$clog2(DEPTH)-1:0] commit_tag,
    output logic [OPC_W-1:0]         commit_opcode,
    output logic [3:0]               commit_dest,
    output logic [DATA_W-1:0]        commit_value,
    output logic                     commit_regwr,
    input  logic                     flush,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      CNT_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW:0]      CNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0]    PTR_ONE   = AW'(1);
    localparam logic [OPC_W-1:0] OPC_STORE = OPC_W'(4'b0100);

    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  done;
    logic [OPC_W-1:0]  opc_mem  [DEPTH];
    logic [3:0]        dest_mem [DEPTH];
    logic [DATA_W-1:0] val_mem  [DEPTH];
    logic [AW-1:0]     head;
    logic [AW-1:0]     tail;
    logic [AW:0]       cnt;

    logic do_alloc;
    logic do_commit;
    logic do_wb;

    // Readiness comes from the registered count only, so a full ROB refuses
    // allocation even when the head retires in the same cycle.
    assign alloc_ready = (cnt < CNT_FULL);
    assign do_alloc    = alloc_valid && alloc_ready;
    assign commit_valid = busy[head] && done[head];
    assign do_commit   = commit_valid && commit_ready;
    assign do_wb       = wb_valid && busy[wb_tag] && !(do_alloc && (wb_tag == tail));

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            busy <= '0;
            done <= '0;
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (do_wb) begin
                done[wb_tag] <= 1'b1;
            end
            if (do_commit) begin
                busy[head] <= 1'b0;
                done[head] <= 1'b0;
                head       <= head + PTR_ONE;
            end
            if (do_alloc) begin
                busy[tail] <= 1'b1;
                done[tail] <= 1'b0;
                tail       <= tail + PTR_ONE;
            end
            case ({do_alloc, do_commit})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase
        end
    end

    // Payload storage is qualified by busy, so it carries no reset.
    always_ff @(posedge clk) begin
        if (do_alloc) begin
            opc_mem[tail]  <= alloc_opcode;
            dest_mem[tail] <= alloc_dest;
        end
        if (do_wb) begin
            val_mem[wb_tag] <= wb_value;
        end
    end

    assign alloc_tag     = tail;
    assign commit_tag    = head;
    assign commit_opcode = opc_mem[head];
    assign commit_dest   = dest_mem[head];
    assign commit_value  = val_mem[head];
    assign commit_regwr  = commit_valid && (opc_mem[head] != OPC_STORE);
    assign full          = (cnt == CNT_FULL);
    assign empty         = (cnt == '0);
    assign count         = cnt;

endmodule

// File: tb/tb_rob_retire.sv
// Randomized and directed bench for rob_retire, checked every cycle against an
// in-order queue model of the reorder buffer.
module tb_rob_retire;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       alloc_valid;
    logic       alloc_ready;
    logic [3:0] alloc_opcode;
    logic [3:0] alloc_dest;
    logic [2:0] alloc_tag;
    logic       wb_valid;
    logic [2:0] wb_tag;
    logic [7:0] wb_value;
    logic       commit_valid;
    logic       commit_ready;
    logic [2:0] commit_tag;
    logic [3:0] commit_opcode;
    logic [3:0] commit_dest;
    logic [7:0] commit_value;
    logic       commit_regwr;
    logic       flush;
    logic       full;
    logic       empty;
    logic [3:0] count;

    rob_retire #(.DEPTH(8), .DATA_W(8), .OPC_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_opcode(alloc_opcode), .alloc_dest(alloc_dest), .alloc_tag(alloc_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
        .commit_valid(commit_valid), .commit_ready(commit_ready),
        .commit_tag(commit_tag), .commit_opcode(commit_opcode),
        .commit_dest(commit_dest), .commit_value(commit_value),
        .commit_regwr(commit_regwr), .flush(flush),
        .full(full), .empty(empty), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] tag;
        logic [3:0] opc;
        logic [3:0] dest;
        logic [7:0] val;
        bit         done;
    } ent_t;

    ent_t       q[$];
    logic [2:0] m_tail;
    bit         known;
    int         n_checks;
    int         n_errors;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input bit av, input logic [3:0] opc, input logic [3:0] dest,
                         input bit wbv, input logic [2:0] wbt, input logic [7:0] wbval,
                         input bit cr, input bit fl, input bit rs);
        bit exp_cv;
        bit exp_ar;
        @(negedge clk);
        alloc_valid  = av;
        alloc_opcode = opc;
        alloc_dest   = dest;
        wb_valid     = wbv;
        wb_tag       = wbt;
        wb_value     = wbval;
        commit_ready = cr;
        flush        = fl;
        rst_n        = rs;
        #1;
        exp_ar = (q.size() < 8);
        exp_cv = (q.size() > 0) && q[0].done;
        if (known) begin
            chk("alloc_ready", alloc_ready, exp_ar);
            chk("alloc_tag", alloc_tag, m_tail);
            chk("count", count, q.size());
            chk("full", full, q.size() == 8);
            chk("empty", empty, q.size() == 0);
            chk("commit_valid", commit_valid, exp_cv);
            if (exp_cv) begin
                chk("commit_tag", commit_tag, q[0].tag);
                chk("commit_opcode", commit_opcode, q[0].opc);
                chk("commit_dest", commit_dest, q[0].dest);
                chk("commit_value", commit_value, q[0].val);
                chk("commit_regwr", commit_regwr, q[0].opc != 4'b0100);
            end else begin
                chk("commit_regwr_idle", commit_regwr, 0);
            end
        end
        @(posedge clk);
        if (!rs || fl) begin
            q.delete();
            m_tail = 3'd0;
            if (!rs) known = 1'b1;
        end else begin
            if (wbv) begin
                foreach (q[i]) begin
                    if (q[i].tag == wbt) begin
                        q[i].done = 1'b1;
                        q[i].val  = wbval;
                    end
                end
            end
            if (exp_cv && cr) void'(q.pop_front());
            if (av && exp_ar) begin
                q.push_back('{tag: m_tail, opc: opc, dest: dest, val: 8'h00, done: 1'b0});
                m_tail = m_tail + 3'd1;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        cycle(0, 4'h0, 4'h0, 0, 3'd0, 8'h00, 0, 0, 0);
    endtask

    task automatic alloc(input logic [3:0] opc, input logic [3:0] dest);
        cycle(1, opc, dest, 0, 3'd0, 8'h00, 0, 0, 1);
    endtask

    task automatic wb(input logic [2:0] t, input logic [7:0] v, input bit cr);
        cycle(0, 4'h0, 4'h0, 1, t, v, cr, 0, 1);
    endtask

    initial begin
        logic [2:0] t;
        logic [3:0] opc;
        n_checks = 0;
        n_errors = 0;
        known    = 1'b0;
        m_tail   = 3'd0;
        rst_n = 1'b0; alloc_valid = 1'b0; alloc_opcode = '0; alloc_dest = '0;
        wb_valid = 1'b0; wb_tag = '0; wb_value = '0; commit_ready = 1'b0; flush = 1'b0;

        // reset state
        do_reset();
        chk("rst_alloc_ready", alloc_ready, 1);
        chk("rst_commit_valid", commit_valid, 0);
        chk("rst_commit_regwr", commit_regwr, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_alloc_tag", alloc_tag, 0);
        chk("rst_count", count, 0);

        // single add r3 round trip
        alloc(4'h1, 4'd3);
        wb(3'd0, 8'h2A, 0);
        chk("basic_cv", commit_valid, 1);
        chk("basic_dest", commit_dest, 3);
        chk("basic_value", commit_value, 8'h2A);
        chk("basic_regwr", commit_regwr, 1);
        wb(3'd0, 8'h00, 1);
        chk("basic_empty", empty, 1);

        // out-of-order writeback, in-order retire
        do_reset();
        alloc(4'h1, 4'd1); alloc(4'h2, 4'd2); alloc(4'h3, 4'd3);
        wb(3'd2, 8'h22, 1);
        chk("ooo_cv_after_wb2", commit_valid, 0);
        wb(3'd1, 8'h11, 1);
        chk("ooo_cv_after_wb1", commit_valid, 0);
        wb(3'd0, 8'h10, 0);
        chk("ooo_cv_after_wb0", commit_valid, 1);
        chk("ooo_tag0", commit_tag, 0);
        wb(3'd7, 8'h00, 1);
        chk("ooo_tag1", commit_tag, 1);
        wb(3'd7, 8'h00, 1);
        chk("ooo_tag2", commit_tag, 2);
        wb(3'd7, 8'h00, 1);
        chk("ooo_empty", empty, 1);

        // fill, then refused alloc during commit
        do_reset();
        for (int i = 0; i < 8; i++) alloc(4'h1, 4'(i));
        chk("fill_full", full, 1);
        chk("fill_alloc_ready", alloc_ready, 0);
        chk("fill_count", count, 8);
        wb(3'd0, 8'h55, 0);
        cycle(1, 4'h1, 4'hF, 0, 3'd0, 8'h00, 1, 0, 1);
        chk("fill_count_after", count, 7);
        chk("fill_tail_kept", alloc_tag, 0);

        // store does not write the register file
        do_reset();
        alloc(4'b0100, 4'd5);
        wb(3'd0, 8'h77, 0);
        chk("store_cv", commit_valid, 1);
        chk("store_regwr", commit_regwr, 0);

        // pointer wrap over 20 cycles
        do_reset();
        for (int i = 0; i < 20; i++)
            cycle(1, 4'h2, 4'(i), i > 0, 3'(i - 1), 8'(i * 7), 1, 0, 1);
        chk("wrap_count", count, q.size());
        chk("wrap_tail", alloc_tag, 4);

        // flush overrides everything
        do_reset();
        for (int i = 0; i < 5; i++) alloc(4'h1, 4'(i));
        wb(3'd0, 8'h01, 0);
        cycle(1, 4'h1, 4'h9, 1, 3'd1, 8'h99, 1, 1, 1);
        chk("flush_count", count, 0);
        chk("flush_empty", empty, 1);
        chk("flush_cv", commit_valid, 0);
        chk("flush_tag", alloc_tag, 0);

        // randomized traffic with occasional flush and mid-run reset
        for (int i = 0; i < 3000; i++) begin
            t = 3'($urandom_range(0, 7));
            if (q.size() > 0 && $urandom_range(0, 3) != 0)
                t = q[$urandom_range(0, q.size() - 1)].tag;
            opc = ($urandom_range(0, 3) == 0) ? 4'b0100 : 4'($urandom);
            cycle($urandom_range(0, 9) < 6, opc, 4'($urandom),
                  $urandom_range(0, 9) < 5, t, 8'($urandom),
                  $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 2,
                  $urandom_range(0, 199) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rob_retire.md
ROB_RETIRE -- requirements
Module: rob_retire

Interface
REQ-001 SHALL have parameter DEPTH, 8, number of ROB entries (power of two).
REQ-002 SHALL have parameter DATA_W, 8, result value width in bits.
REQ-003 SHALL have parameter OPC_W, 4, opcode width; store opcode is 4'b0100.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port alloc_valid  input  1  dispatch requests a new entry.
REQ-007 SHALL have port alloc_ready  output  1  entry available (not full).
REQ-008 SHALL have port alloc_opcode  input  OPC_W  opcode of dispatched instruction.
REQ-009 SHALL have port alloc_dest  input  4  architectural destination register.
REQ-010 SHALL have port alloc_tag  output  log2(DEPTH)  tag assigned; equals tail pointer.
REQ-011 SHALL have port wb_valid  input  1  result broadcast present.
REQ-012 SHALL have port wb_tag  input  log2(DEPTH)  ROB tag of broadcast result.
REQ-013 SHALL have port wb_value  input  DATA_W  broadcast result value.
REQ-014 SHALL have port commit_valid  output  1  head entry ready to retire.
REQ-015 SHALL have port commit_ready  input  1  register file/store port accepts retire.
REQ-016 SHALL have port commit_tag, commit_opcode, commit_dest, commit_value  output  log2(DEPTH)/OPC_W/4/DATA_W  head entry fields.
REQ-017 SHALL have port commit_regwr  output  1  retire writes register file (0 for store).
REQ-018 SHALL have port flush  input  1  discard all entries.
REQ-019 SHALL have ports full, empty  output  1  each; count  output  log2(DEPTH)+1  occupancy.

Function
REQ-020 SHALL hold per entry: busy, opcode, dest, value, done; head, tail pointers; count.
REQ-021 SHALL assert alloc_ready = (count < DEPTH), from registered count only.
REQ-022 SHALL on alloc_valid && alloc_ready write entry[tail] (busy=1, done=0), return alloc_tag=tail combinationally, advance tail modulo DEPTH.
REQ-023 SHALL on wb_valid with entry[wb_tag].busy=1 store wb_value and set done=1; wb to non-busy tag SHALL be ignored.
REQ-024 SHALL assert commit_valid = entry[head].busy && entry[head].done (registered state; wb reaching head becomes visible the following cycle).
REQ-025 SHALL drive commit_* from entry[head] at all times; commit_regwr = commit_valid && opcode != 4'b0100.
REQ-026 SHALL on commit_valid && commit_ready clear entry[head].busy/done and advance head modulo DEPTH.
REQ-027 SHALL retire strictly in allocation order; at most one alloc and one commit per cycle.
REQ-028 SHALL on simultaneous alloc and commit keep count unchanged; when full, alloc SHALL be refused even if commit occurs same cycle.
REQ-029 SHALL when wb targets the entry being allocated in the same cycle ignore the wb (allocation wins).
REQ-030 SHALL wrap head/tail from DEPTH-1 to 0 with no loss of entries.
REQ-031 SHALL on flush clear all busy/done, head=tail=0, count=0; flush overrides alloc, wb, commit that cycle.
REQ-032 SHALL set full = (count == DEPTH), empty = (count == 0).

Reset
REQ-033 SHALL on rst_n=0 at clk edge set head=tail=0, count=0, all busy/done=0; outputs: alloc_ready=1, commit_valid=0, commit_regwr=0, empty=1, full=0, alloc_tag=0.
REQ-034 SHALL treat reset mid-operation identically to flush; value/opcode/dest storage need not reset.

Verification
REQ-035 Reset, then alloc add r3 (tag 0), wb tag0 value 8'h2A -> next cycle commit_valid=1, commit_dest=3, commit_value=2A, commit_regwr=1; commit_ready=1 -> empty=1.
REQ-036 Alloc tags 0,1,2; wb order 2,1,0 -> commits occur in order 0,1,2 only; commit_valid low until tag0 done.
REQ-037 Alloc 8 entries -> full=1, alloc_ready=0, count=8; 9th alloc with simultaneous commit -> refused, count=7 afterward.
REQ-038 Store opcode 4'b0100 allocated, wb done -> commit_valid=1, commit_regwr=0.
REQ-039 Run 20 alloc/wb/commit cycles so head/tail wrap past 7 -> tags 0..7 reused, order preserved, count correct.
REQ-040 With 5 entries busy assert flush (also wb and commit_ready high) -> next cycle count=0, empty=1, commit_valid=0, alloc_tag=0.
